// File: rtl/const_alu_pkg.sv
// Shared types for the constant-operand ALU pipeline: opcode encoding and
// the per-result flag bundle produced by the stage-2 datapath.
package const_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ACC = 2'd2,
    OP_CMP = 2'd3
  } op_t;

  typedef struct packed {
    logic sticky_set;
    logic status;
  } res_flags_t;

  // CMP reports ordering, not overflow, so it never touches the sticky flag.
  function automatic logic affects_sticky(op_t op);
    return op != OP_CMP;
  endfunction

endpackage

// File: rtl/const_table.sv
// NCONST x WIDTH constant register file: one write port, one combinational
// read port; a same-cycle write is not visible on the read port until the next edge.
module const_table #(
  parameter int                      WIDTH      = 8,
  parameter int                      NCONST     = 4,
  parameter logic [NCONST*WIDTH-1:0] CONST_INIT = {8'd100, 8'd10, 8'd5, 8'd1},
  localparam int                     SEL_W      = $clog2(NCONST)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             we_i,
  input  logic [SEL_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [SEL_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] tbl_q [NCONST];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < NCONST; i++) begin
        tbl_q[i] <= CONST_INIT[i*WIDTH +: WIDTH];
      end
    end else if (we_i) begin
      tbl_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = tbl_q[raddr_i];

endmodule

// File: rtl/const_alu_pipe.sv
// Two-stage valid/ready ALU combining an operand with a run-time constant or
// the accumulator; stage 1 captures operands, stage 2 computes and holds the result.
module const_alu_pipe
  import const_alu_pkg::*;
#(
  parameter int                      WIDTH      = 8,
  parameter int                      NCONST     = 4,
  parameter logic [NCONST*WIDTH-1:0] CONST_INIT = {8'd100, 8'd10, 8'd5, 8'd1},
  parameter bit                      SATURATE   = 1'b0,
  localparam int                     SEL_W      = $clog2(NCONST)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0] in_sel_i,
  input  logic [1:0]       in_op_i,
  input  logic             cfg_we_i,
  input  logic [SEL_W-1:0] cfg_addr_i,
  input  logic [WIDTH-1:0] cfg_data_i,
  input  logic             acc_clr_i,
  input  logic             sticky_clr_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_status_o,
  output logic             sticky_ovf_o
);

  logic [WIDTH-1:0] k_rd;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_k_q, s1_k_d;
  op_t              s1_op_q, s1_op_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_status_q, out_status_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;

  logic             s2_load;
  logic [WIDTH-1:0] acc_use;
  logic [WIDTH:0]   sum_add, diff_sub, sum_acc;
  logic [WIDTH-1:0] res_data;
  res_flags_t       res_flags;

  const_table #(
    .WIDTH     (WIDTH),
    .NCONST    (NCONST),
    .CONST_INIT(CONST_INIT)
  ) u_table (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .we_i     (cfg_we_i),
    .waddr_i  (cfg_addr_i),
    .wdata_i  (cfg_data_i),
    .raddr_i  (in_sel_i),
    .rdata_o  (k_rd)
  );

  assign s2_load    = !out_valid_q || out_ready_i;
  assign in_ready_o = !s1_valid_q || s2_load;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_k_d     = s1_k_q;
    s1_op_d    = s1_op_q;
    if (in_ready_o) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_a_d  = in_data_i;
        s1_k_d  = k_rd;
        s1_op_d = op_t'(in_op_i);
      end
    end
  end

  // A clear on the same edge as an ACC entering stage 2 makes that ACC start from zero.
  assign acc_use  = acc_clr_i ? '0 : acc_q;
  assign sum_add  = {1'b0, s1_a_q} + {1'b0, s1_k_q};
  assign diff_sub = {1'b0, s1_a_q} - {1'b0, s1_k_q};
  assign sum_acc  = {1'b0, acc_use} + {1'b0, s1_a_q};

  always_comb begin
    res_data         = sum_add[WIDTH-1:0];
    res_flags.status = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        res_flags.status = sum_add[WIDTH];
        res_data         = (SATURATE && sum_add[WIDTH]) ? '1 : sum_add[WIDTH-1:0];
      end
      OP_SUB: begin
        res_flags.status = diff_sub[WIDTH];
        res_data         = (SATURATE && diff_sub[WIDTH]) ? '0 : diff_sub[WIDTH-1:0];
      end
      OP_ACC: begin
        res_flags.status = sum_acc[WIDTH];
        res_data         = (SATURATE && sum_acc[WIDTH]) ? '1 : sum_acc[WIDTH-1:0];
      end
      OP_CMP: begin
        res_flags.status = (s1_a_q >= s1_k_q);
        res_data         = (s1_a_q >= s1_k_q) ? s1_a_q : s1_k_q;
      end
      default: ;
    endcase
    res_flags.sticky_set = res_flags.status && affects_sticky(s1_op_q);
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_status_d = out_status_q;
    acc_d        = acc_clr_i ? '0 : acc_q;
    sticky_d     = sticky_clr_i ? 1'b0 : sticky_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d   = res_data;
        out_status_d = res_flags.status;
        if (s1_op_q == OP_ACC) begin
          acc_d = res_data;
        end
        if (res_flags.sticky_set) begin
          sticky_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_k_q       <= '0;
      s1_op_q      <= OP_ADD;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_status_q <= 1'b0;
      acc_q        <= '0;
      sticky_q     <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_k_q       <= s1_k_d;
      s1_op_q      <= s1_op_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_status_q <= out_status_d;
      acc_q        <= acc_d;
      sticky_q     <= sticky_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_status_o = out_status_q;
  assign sticky_ovf_o = sticky_q;

endmodule
